// File: rtl/pipe_pkg.sv
// Shared definitions for the D/E/M/W pipeline stage registers.
//   stage_state_t : occupancy-encoded stage state, so the state value
//                   doubles as the entry count
//   PIPE_NOP      : default bubble payload, all-zero, which decodes as a NOP
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } stage_state_t;

   localparam logic [63:0] PIPE_NOP = 64'h0;

endpackage

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with an optional 2-entry skid buffer.
//   clk, reset (sync, active-low)
//   flush                       : squash all held and incoming payloads
//   in_valid/in_ready/in_data   : upstream handshake
//   out_valid/out_ready/out_data: downstream handshake; out_data is
//                                 BUBBLE_VAL whenever out_valid=0
//   occupancy                   : held entries, 0..2
//   flushed                     : one-cycle pulse after a flush that killed
//                                 at least one live payload
//
// state | meaning
// EMPTY | nothing held, out_valid=0
// ONE   | main holds the head payload
// FULL  | main holds the head, skid holds the next payload (SKID_EN=1 only)
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                 DATA_W     = 64,
   parameter logic [DATA_W-1:0]  BUBBLE_VAL = DATA_W'(PIPE_NOP),
   parameter bit                 SKID_EN    = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic              flushed
);

   stage_state_t      state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q;
   logic              load_skid;
   logic              rdy_q;
   logic              flushed_q;
   logic              push, pop;
   logic [2:0]        live_cnt;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   // Entries that would survive this cycle had there been no flush; a pop
   // concurrent with the flush has already been consumed downstream.
   assign live_cnt = 3'(state_q) - 3'(pop) + 3'(push);

   always_comb begin
      state_d   = state_q;
      main_d    = main_q;
      load_skid = 1'b0;
      if (flush) begin
         state_d = EMPTY;
         main_d  = BUBBLE_VAL;
      end else begin
         case (state_q)
            EMPTY: begin
               if (push) begin
                  state_d = ONE;
                  main_d  = in_data;
               end
            end
            ONE: begin
               if (push && pop) begin
                  main_d = in_data;
               end else if (pop) begin
                  state_d = EMPTY;
               end else if (push) begin
                  // Only reachable with the skid buffer present; the
                  // single-entry variant never accepts without a pop.
                  state_d   = FULL;
                  load_skid = 1'b1;
               end
            end
            FULL: begin
               if (pop) begin
                  state_d = ONE;
                  main_d  = skid_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= EMPTY;
         main_q    <= BUBBLE_VAL;
         rdy_q     <= 1'b0;
         flushed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         main_q    <= main_d;
         rdy_q     <= (state_d != FULL);
         flushed_q <= flush & (live_cnt != 3'd0);
      end
   end

   generate
      if (SKID_EN) begin : g_skid
         always_ff @(posedge clk) begin
            if (!reset || flush) begin
               skid_q <= BUBBLE_VAL;
            end else if (load_skid) begin
               skid_q <= in_data;
            end
         end
         assign in_ready = rdy_q;
      end else begin : g_single
         assign skid_q   = BUBBLE_VAL;
         // Without a skid entry, ONE can only accept when the head leaves in
         // the same cycle, hence the pass-through of out_ready.
         assign in_ready = rdy_q & ((state_q == EMPTY) | out_ready);
      end
   endgenerate

   assign out_valid = (state_q != EMPTY);
   assign out_data  = out_valid ? main_q : BUBBLE_VAL;
   assign occupancy = state_q;
   assign flushed   = flushed_q;

endmodule
